// File: rtl/pin_lock_pkg.sv
// rtl/pin_lock_pkg.sv - shared FSM state type and counter sizing helper for pin_sequence_lock
package pin_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_UNLOCK  = 2'd2,
    ST_LOCKOUT = 2'd3
  } lock_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with done flag, shared by UNLOCK and LOCKOUT
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/pin_sequence_lock.sv
// rtl/pin_sequence_lock.sv - PIN entry lock with timed unlock; PIN_LOCKOUT_EN adds attempt counting and lockout
module pin_sequence_lock
  import pin_lock_pkg::*;
#(
  parameter int DIGIT_WIDTH    = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                key,
  input  logic                                clear,
  input  logic [DIGIT_WIDTH-1:0]              digit,
  input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0]   pin,
  output logic                                unlock,
  output logic                                error,
  output logic                                lockedOut,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digitCount
);

  localparam int ENTRY_W = NUM_DIGITS * DIGIT_WIDTH;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int TMAX    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = cnt_width(TMAX);

  lock_state_t        r_state;
  lock_state_t        w_next;
  logic [ENTRY_W-1:0] r_entry;
  logic [CNT_W-1:0]   r_count;
  logic               r_error;
  logic               w_match;
  logic               w_key_last;
  logic               w_go_lockout;
  logic               w_timer_load;
  logic               w_timer_done;
  logic [TIMER_W-1:0] w_timer_value;

  assign w_match    = (r_entry == pin);
  assign w_key_last = key && !clear && (r_count == CNT_W'(NUM_DIGITS - 1));

`ifdef PIN_LOCKOUT_EN
  localparam int ATT_W = cnt_width(MAX_ATTEMPTS);
  logic [ATT_W-1:0] r_attempts;

  assign w_go_lockout = (r_attempts == ATT_W'(MAX_ATTEMPTS - 1));

  // Zeroed on the failure that triggers lockout, so ENTRY resumes with a fresh count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_attempts <= '0;
    end else if (r_state == ST_CHECK) begin
      r_attempts <= (w_match || w_go_lockout) ? '0 : r_attempts + ATT_W'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_ATTEMPTS > 0);
  assign w_go_lockout = 1'b0;
`endif

  assign w_timer_load  = (r_state == ST_CHECK) && (w_match || w_go_lockout);
  assign w_timer_value = w_match ? TIMER_W'(UNLOCK_CYCLES - 1) : TIMER_W'(LOCKOUT_CYCLES - 1);

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_timer_load),
    .i_value (w_timer_value),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_ENTRY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ENTRY:   if (w_key_last) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_match)           w_next = ST_UNLOCK;
        else if (w_go_lockout) w_next = ST_LOCKOUT;
        else                   w_next = ST_ENTRY;
      end
      ST_UNLOCK:  if (w_timer_done) w_next = ST_ENTRY;
      ST_LOCKOUT: if (w_timer_done) w_next = ST_ENTRY;
      default:    w_next = ST_ENTRY;
    endcase
  end

  always_comb begin
    unlock     = (r_state == ST_UNLOCK);
`ifdef PIN_LOCKOUT_EN
    lockedOut  = (r_state == ST_LOCKOUT);
`else
    lockedOut  = 1'b0;
`endif
    error      = r_error;
    digitCount = r_count;
  end

  // Shifting left keeps the first digit in the MSB slice once the entry is complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_entry <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= (r_state == ST_CHECK) && !w_match;
      case (r_state)
        ST_ENTRY: begin
          if (clear) begin
            r_entry <= '0;
            r_count <= '0;
          end else if (key) begin
            r_entry <= (r_entry << DIGIT_WIDTH) | ENTRY_W'(digit);
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          r_entry <= '0;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
